// File: rtl/exec_seq_ctrl_if.sv
// Memory handshake bundle between the sequencer (master) and the instruction/data memories (slave).
interface exec_seq_ctrl_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ready, dmem_ready
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ready, dmem_ready
    );
endinterface

// File: rtl/exec_seq_ctrl.sv
// Multi-cycle rv32i sequencer: owns the PC, steps fetch/decode/execute/mem/writeback, memory watchdog.
// Optional performance counters are enabled by defining EXEC_SEQ_PERF_CNT_EN.
//
// state    | meaning
// FETCH    | imem request outstanding, latch IR on imem_ready
// DECODE   | decode outputs valid, trap on illegal
// EXEC_OP  | execute operand registers capture
// EXEC_ALU | alu result and pc_next valid
// MEM      | data memory request outstanding
// WB       | register write, PC update, retire
// HALT     | core stopped until reset
module exec_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    exec_seq_ctrl_if.master mem_bus,
    output logic [31:0] pc,
    input  logic [31:0] pc_next,
    output logic        ir_we,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        wb_en,
    input  logic        illegal,
    output logic        op_latch,
    output logic        rf_we,
    output logic        pc_we,
    output logic        retire,
    output logic        halted,
    output logic        bus_err
`ifdef EXEC_SEQ_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    typedef enum logic [2:0] {
        FETCH    = 3'd0,
        DECODE   = 3'd1,
        EXEC_OP  = 3'd2,
        EXEC_ALU = 3'd3,
        MEM      = 3'd4,
        WB       = 3'd5,
        HALT     = 3'd6
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       wd_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            wait_cnt <= 8'd0;
            pc       <= RESET_PC;
            bus_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (pc_we)
                pc <= pc_next;
            if (wd_fire)
                bus_err <= 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        wd_fire      = 1'b0;
        wait_cnt_nxt = 8'd0;
        case (state)
            FETCH: begin
                if (mem_bus.imem_ready) begin
                    state_nxt = DECODE;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    state_nxt = HALT;
                    wd_fire   = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            DECODE:   state_nxt = illegal ? HALT : EXEC_OP;
            EXEC_OP:  state_nxt = EXEC_ALU;
            EXEC_ALU: state_nxt = (is_load || is_store) ? MEM : WB;
            MEM: begin
                if (mem_bus.dmem_ready) begin
                    state_nxt = WB;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    state_nxt = HALT;
                    wd_fire   = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            WB:       state_nxt = FETCH;
            HALT:     state_nxt = HALT;
            default:  state_nxt = FETCH;
        endcase
    end

    // Moore outputs; only ir_we looks at the fetch handshake
    assign mem_bus.imem_req = (state == FETCH);
    assign ir_we            = (state == FETCH) && mem_bus.imem_ready;
    assign op_latch         = (state == EXEC_OP);
    assign mem_bus.dmem_req = (state == MEM);
    assign mem_bus.dmem_we  = (state == MEM) && is_store;
    assign rf_we            = (state == WB) && wb_en && !is_store;
    assign pc_we            = (state == WB);
    assign retire           = (state == WB);
    assign halted           = (state == HALT);

`ifdef EXEC_SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= 32'd0;
            instret_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (retire)
                instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_exec_seq_ctrl.sv
// Scoreboard bench for exec_seq_ctrl: stimulus queues expected retire/halt events, a monitor checks them.
module tb_exec_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_next = 32'h0;
    logic        ir_we, op_latch, rf_we, pc_we, retire, halted, bus_err;
    logic        is_load = 1'b0, is_store = 1'b0, wb_en = 1'b0, illegal = 1'b0;
`ifdef EXEC_SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    exec_seq_ctrl_if bus ();

    always #5 clk = ~clk;

    exec_seq_ctrl #(.RESET_PC(32'h0000_0000), .MAX_WAIT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_bus  (bus),
        .pc       (pc),
        .pc_next  (pc_next),
        .ir_we    (ir_we),
        .is_load  (is_load),
        .is_store (is_store),
        .wb_en    (wb_en),
        .illegal  (illegal),
        .op_latch (op_latch),
        .rf_we    (rf_we),
        .pc_we    (pc_we),
        .retire   (retire),
        .halted   (halted),
        .bus_err  (bus_err)
`ifdef EXEC_SEQ_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_halt;
        int          cyc;
        logic [31:0] pc;
        logic        rf_we;
        int          dreq;
        int          dwe;
        logic [31:0] new_pc;
        logic        bus_err;
    } exp_t;

    exp_t sbq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // monitor: pops the scoreboard whenever the DUT retires or enters HALT
    int          dreq_cnt = 0;
    int          dwe_cnt = 0;
    logic        halted_q = 1'b0;
    bit          pc_chk = 0;
    logic [31:0] pc_exp = 32'h0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            dreq_cnt = 0;
            dwe_cnt  = 0;
            halted_q = 1'b0;
            pc_chk   = 0;
        end else begin
            if (pc_chk) begin
                check("pc_after_wb", pc, pc_exp);
                pc_chk = 0;
            end
            if (bus.dmem_req) dreq_cnt++;
            if (bus.dmem_we) dwe_cnt++;
            if (rf_we && !retire) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rf_we_outside_wb: got 1 expected 0 at cycle %0d", cyc);
            end
            if (retire) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_retire: got retire at cycle %0d expected none", cyc);
                end else begin
                    e = sbq.pop_front();
                    check("event_kind_retire", {31'b0, retire && halted}, {31'b0, e.is_halt});
                    check("retire_cycle", cyc, e.cyc);
                    check("retire_pc", pc, e.pc);
                    check("retire_rf_we", {31'b0, rf_we}, {31'b0, e.rf_we});
                    check("dmem_req_cycles", dreq_cnt, e.dreq);
                    check("dmem_we_cycles", dwe_cnt, e.dwe);
                    pc_exp = e.new_pc;
                    pc_chk = 1;
                end
                dreq_cnt = 0;
                dwe_cnt  = 0;
            end
            if (halted && !halted_q) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_halt: got halt at cycle %0d expected none", cyc);
                end else begin
                    e = sbq.pop_front();
                    check("event_kind_halt", 32'd1, {31'b0, e.is_halt});
                    check("halt_cycle", cyc, e.cyc);
                    check("halt_bus_err", {31'b0, bus_err}, {31'b0, e.bus_err});
                end
            end
            halted_q = halted;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called one time unit after the edge that put the DUT into FETCH.
    task automatic run_instr(input logic [31:0] cur_pc, input logic ld, input logic st, input logic wb,
                             input logic [31:0] nxt, input int fwait, input int mwait);
        exp_t e;
        bit   is_mem;
        is_mem    = ld | st;
        e.is_halt = 0;
        e.cyc     = cyc + 4 + fwait + (is_mem ? mwait + 1 : 0);
        e.pc      = cur_pc;
        e.rf_we   = wb & ~st;
        e.dreq    = is_mem ? mwait + 1 : 0;
        e.dwe     = st ? mwait + 1 : 0;
        e.new_pc  = nxt;
        e.bus_err = 1'b0;
        sbq.push_back(e);
        is_load  = ld;
        is_store = st;
        wb_en    = wb;
        illegal  = 1'b0;
        pc_next  = nxt;
        for (int i = 0; i < fwait; i++) begin
            bus.imem_ready = 1'b0;
            step();
        end
        bus.imem_ready = 1'b1;
        #1;
        check("ir_we_on_ready", {31'b0, ir_we}, 32'd1);
        step();
        bus.imem_ready = 1'b0;
        step();
        check("op_latch_in_exec_op", {31'b0, op_latch}, 32'd1);
        step();
        step();
        if (is_mem) begin
            for (int i = 0; i < mwait; i++) begin
                bus.dmem_ready = 1'b0;
                step();
            end
            bus.dmem_ready = 1'b1;
            step();
            bus.dmem_ready = 1'b0;
        end
        step();
    endtask

    task automatic push_halt(input int at_cyc, input logic berr);
        exp_t e;
        e.is_halt = 1;
        e.cyc     = at_cyc;
        e.pc      = 32'h0;
        e.rf_we   = 1'b0;
        e.dreq    = 0;
        e.dwe     = 0;
        e.new_pc  = 32'h0;
        e.bus_err = berr;
        sbq.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        is_load = 1'b0; is_store = 1'b0; wb_en = 1'b0; illegal = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        step();
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_imem_req", {31'b0, bus.imem_req}, 32'd1);
        check("rst_outputs_low",
              {24'b0, ir_we, op_latch, bus.dmem_req, bus.dmem_we, rf_we, pc_we, retire, halted}, 32'd0);
        check("rst_bus_err", {31'b0, bus_err}, 32'd0);
        step();
        rst_n = 1'b1;

        run_instr(32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0004, 0, 0);   // ALU, 5 cycles
        run_instr(32'h0000_0004, 1'b0, 1'b1, 1'b1, 32'h0000_0008, 0, 3);   // store, ready after 3 waits
        run_instr(32'h0000_0008, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 0, 0);   // load, taken branch
        run_instr(32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0000_0104, 2, 0);   // no rd, slow fetch
        run_instr(32'h0000_0104, 1'b0, 1'b0, 1'b1, 32'h0000_0108, 3, 0);   // fetch ready on 4th cycle
        run_instr(32'h0000_0108, 1'b0, 1'b1, 1'b0, 32'h0000_010c, 0, 3);
        check("not_halted_after_max_waits", {31'b0, halted}, 32'd0);
`ifdef EXEC_SEQ_PERF_CNT_EN
        check("instret_cnt", instret_cnt, 32'd6);
`endif

        // reset while a load is stuck in MEM
        is_load = 1'b1; is_store = 1'b0; wb_en = 1'b1; pc_next = 32'h0000_0200;
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready = 1'b0;
        step(); step(); step();
        step();
        check("mem_req_before_reset", {31'b0, bus.dmem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_mem_rst_pc", pc, 32'h0);
        check("mid_mem_rst_dmem_req", {31'b0, bus.dmem_req}, 32'd0);
        check("mid_mem_rst_imem_req", {31'b0, bus.imem_req}, 32'd1);
`ifdef EXEC_SEQ_PERF_CNT_EN
        check("rst_cycle_cnt", cycle_cnt, 32'd0);
        check("rst_instret_cnt", instret_cnt, 32'd0);
`endif
        do_reset();

        run_instr(32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0020, 0, 0);
        // illegal instruction at 0x20
        push_halt(cyc + 2, 1'b0);
        illegal = 1'b1;
        pc_next = 32'h0000_0024;
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready = 1'b0;
        step();
        for (int i = 0; i < 20; i++) step();
        check("illegal_still_halted", {31'b0, halted}, 32'd1);
        check("illegal_pc_held", pc, 32'h0000_0020);
        check("illegal_bus_err", {31'b0, bus_err}, 32'd0);
        check("halt_imem_req", {31'b0, bus.imem_req}, 32'd0);
        do_reset();

        // fetch never acknowledged: watchdog fires on the 4th waiting cycle
        push_halt(cyc + 4, 1'b1);
        for (int i = 0; i < 6; i++) step();
        check("fetch_wd_halted", {31'b0, halted}, 32'd1);
        check("fetch_wd_bus_err", {31'b0, bus_err}, 32'd1);
        do_reset();

        // data access never acknowledged
        run_instr(32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0004, 0, 0);
        is_load = 1'b1; wb_en = 1'b1; pc_next = 32'h0000_0300;
        push_halt(cyc + 8, 1'b1);
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("mem_wd_halted", {31'b0, halted}, 32'd1);
        check("mem_wd_dmem_req", {31'b0, bus.dmem_req}, 32'd0);
        check("mem_wd_pc_held", pc, 32'h0000_0004);
        step();

        check("scoreboard_drained", sbq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
